io_bridge: RTL and testbench
============================

# io_bridge

Parametrised memory-mapped I/O block that replaces the single 8-bit LED latch and raw switch input of the core top level. It sits on the core's data-memory bus beside the data RAM and exposes OUT_CH latched output channels and IN_CH input channels. Each input passes through a two-flop synchroniser and a per-channel debounce counter. Sticky change flags are cleared on read.

## Interface
- DATA_W, 32: bus data width.
- IN_CH, 2: input channel count, 1..16.
- OUT_CH, 2: output channel count, 1..16.
- CH_W, 8: bits per channel, 1..DATA_W.
- DEBOUNCE, 4: consecutive cycles of disagreement needed before a debounced input changes, >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- re  in  1  read enable.
- we  in  1  write enable.
- addr  in  32  byte address; word offset k = addr[7:2]; other bits are ignored.
- di  in  DATA_W  write data.
- data  out  DATA_W  read data, combinational.
- pins_in  in  IN_CH*CH_W  raw asynchronous inputs; channel i occupies [i*CH_W +: CH_W].
- pins_out  out  OUT_CH*CH_W  registered outputs; same packing as pins_in.

## Operation
Address map:
- Offsets 0..OUT_CH-1: output register k, read/write.
- Offsets 16..16+IN_CH-1: debounced value of input k-16, read-only.
- Offset 32: status register. Bit i is the change flag of input i; upper bits read 0. Reading clears the flags.
- Any other offset reads 0, and writes to it are ignored. Writes to input or status offsets are ignored.

Writes:
- When we=1 at a rising edge, out[k] <= di[CH_W-1:0].

Reads:
- data = zero-extended register selected by addr when re=1; data = 0 when re=0.

Input path, per channel:
- Sync: s1 <= pin, then s2 <= s1.
- Debounce, evaluated each edge:
  - If s2 == deb, cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE-1: deb <= s2, cnt <= 0, and flag[i] <= 1.
  - Otherwise cnt <= cnt+1.
- Counter width is clog2(DEBOUNCE+1). A glitch shorter than DEBOUNCE cycles at s2 never reaches deb.

Status clear:
- At an edge with re=1 and offset 32, each flag bit that was returned is cleared.
- If the same edge also sets a flag, that flag stays 1. Set wins over clear.

Reset (async, rst=1):
- s1, s2, deb, cnt, flags and all output registers go to 0, so pins_out=0.
- data follows its combinational rule and reads 0 while re=0.
- Nonzero pins present at reset release are debounced normally and raise their flags.

## Timing
- Write latency is one edge: pins_out changes on the edge where we=1.
- Read is same-cycle combinational. A read and a write to the same offset in one cycle return the old value.
- Input latency: a pin change that is stable before edge 1 appears in s2 after edge 2. deb and the flag update on edge 2+DEBOUNCE, e.g. edge 6 for DEBOUNCE=4 and edge 3 for DEBOUNCE=1.
- Flag read: the value is visible in data on the cycle the flag sets; it clears on the following read edge.
- rst asserted mid-debounce aborts the count; no flag is raised for that change.
- re and we may be asserted together at different offsets; both take effect.

## Test plan
- Reset with pins_in=0 and pins_out previously 0xA5 -> pins_out=0, data=0. Reads of offsets 16, 17 and 32 return 0.
- Write 0x1234_56C3 to addr 0x04 -> pins_out[15:8]=0xC3 on that edge, and a read of addr 0x04 returns 0x0000_00C3. A write to addr 0x40 leaves every register unchanged.
- Set pins_in channel 0 to 0x5A before edge 1 with DEBOUNCE=4 -> offset 16 reads 0 through edge 5 and 0x5A after edge 6. Status reads 0x1, then 0x0 on the next read.
- 3-cycle glitch on channel 1 (0x00->0xFF->0x00 at s2) -> the debounced value stays 0x00 and status bit 1 stays 0.
- Status read on the same edge as a channel 1 debounce update, with flag 0 already set -> data=0x1, and after the edge status=0x2.
- Assert rst at edge 4 of a channel 0 debounce -> deb=0, flags=0; after release with the pin still 0x5A, the update happens 2+DEBOUNCE edges later.

Source files
------------

// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - memory-mapped output latches and debounced inputs with sticky change flags
module io_bridge #(
  parameter int DATA_W   = 32,
  parameter int IN_CH    = 2,
  parameter int OUT_CH   = 2,
  parameter int CH_W     = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   re,
  input  logic                   we,
  input  logic [31:0]            addr,
  input  logic [DATA_W-1:0]      di,
  output logic [DATA_W-1:0]      data,
  input  logic [IN_CH*CH_W-1:0]  pins_in,
  output logic [OUT_CH*CH_W-1:0] pins_out
);

  localparam int              CNT_W      = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [5:0]      IN_BASE    = 6'd16;
  localparam logic [5:0]      STATUS_OFF = 6'd32;

  logic [5:0]       k;
  logic             status_rd;
  logic             unused_bits;

  logic [CH_W-1:0]  out_reg [OUT_CH];
  logic [CH_W-1:0]  s1      [IN_CH];
  logic [CH_W-1:0]  s2      [IN_CH];
  logic [CH_W-1:0]  deb     [IN_CH];
  logic [CNT_W-1:0] cnt     [IN_CH];
  logic [IN_CH-1:0] flags;
  logic [IN_CH-1:0] flag_set;

  assign k           = addr[7:2];
  assign status_rd   = re && (k == STATUS_OFF);
  assign unused_bits = ^{addr[31:8], addr[1:0], di};

  // A flag fires on exactly the edge where the debounced value takes the new s2.
  always_comb begin
    flag_set = '0;
    for (int i = 0; i < IN_CH; i++) begin
      flag_set[i] = (s2[i] != deb[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < IN_CH; i++) begin
        s1[i]  <= '0;
        s2[i]  <= '0;
        deb[i] <= '0;
        cnt[i] <= '0;
      end
      flags <= '0;
    end else begin
      for (int i = 0; i < IN_CH; i++) begin
        s1[i] <= pins_in[i*CH_W +: CH_W];
        s2[i] <= s1[i];
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (flag_set[i]) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      // Set wins over the clear-on-read of the same edge.
      flags <= (status_rd ? '0 : flags) | flag_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUT_CH; i++) begin
        out_reg[i] <= '0;
      end
    end else if (we) begin
      for (int i = 0; i < OUT_CH; i++) begin
        if (k == 6'(i)) begin
          out_reg[i] <= di[CH_W-1:0];
        end
      end
    end
  end

  always_comb begin
    data = '0;
    if (re) begin
      for (int i = 0; i < OUT_CH; i++) begin
        if (k == 6'(i)) data = DATA_W'(out_reg[i]);
      end
      for (int i = 0; i < IN_CH; i++) begin
        if (k == IN_BASE + 6'(i)) data = DATA_W'(deb[i]);
      end
      if (status_rd) data = DATA_W'(flags);
    end
  end

  for (genvar g = 0; g < OUT_CH; g++) begin : g_pins_out
    assign pins_out[g*CH_W +: CH_W] = out_reg[g];
  end

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - self-checking bench for io_bridge against a behavioural model
module tb_io_bridge;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [31:0] di;
  logic [31:0] data;
  logic [15:0] pins_in;
  logic [15:0] pins_out;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_out    [2];
  logic [7:0] m_s1     [2];
  logic [7:0] m_s2     [2];
  logic [7:0] m_deb    [2];
  int         m_streak [2];
  logic [1:0] m_flags;

  io_bridge #(.DATA_W(32), .IN_CH(2), .OUT_CH(2), .CH_W(8), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .di(di),
    .data(data), .pins_in(pins_in), .pins_out(pins_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 8'h00; m_s1[i] = 8'h00; m_s2[i] = 8'h00;
      m_deb[i] = 8'h00; m_streak[i] = 0;
    end
    m_flags = 2'b00;
  endtask

  // One rising edge as seen by the model: a value must disagree with deb for DEB
  // consecutive edges before it is adopted.
  task automatic model_edge();
    logic [1:0] set;
    set = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_streak[i] = m_streak[i] + 1;
        if (m_streak[i] == DEB) begin
          m_deb[i] = m_s2[i];
          m_streak[i] = 0;
          set[i] = 1'b1;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
    if (re && addr[7:2] == 6'd32) m_flags = 2'b00;
    m_flags = m_flags | set;
    if (we && addr[7:2] < 6'd2) m_out[addr[2]] = di[7:0];
    for (int i = 0; i < 2; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = pins_in[i*8 +: 8];
    end
  endtask

  function automatic logic [31:0] exp_read();
    logic [5:0] kk;
    kk = addr[7:2];
    if (!re) return 32'h0;
    if (kk < 6'd2) return {24'h0, m_out[kk[0]]};
    if (kk == 6'd16 || kk == 6'd17) return {24'h0, m_deb[kk[0]]};
    if (kk == 6'd32) return {30'h0, m_flags};
    return 32'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    re = r; we = w; addr = a; di = d;
  endtask

  task automatic test_reset();
    drive(0, 1, 32'h0, 32'hA5);
    tick();
    drive(0, 0, 32'h0, 32'h0);
    checks++;
    if (pins_out !== 16'h00A5) begin errors++; $display("FAIL pre_reset_out got=%h exp=%h", pins_out, 16'h00A5); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (pins_out !== 16'h0000) begin errors++; $display("FAIL reset_pins_out got=%h exp=0000", pins_out); end
    checks++;
    if (data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data); end
    tick();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      logic [31:0] a;
      a = (j == 0) ? 32'h40 : (j == 1) ? 32'h44 : 32'h80;
      drive(1, 0, a, 32'h0);
      #1;
      checks++;
      if (data !== 32'h0) begin errors++; $display("FAIL reset_rd addr=%h got=%h exp=0", a, data); end
    end
    drive(0, 0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_write();
    drive(0, 1, 32'h04, 32'h1234_56C3);
    tick();
    checks++;
    if (pins_out[15:8] !== 8'hC3) begin errors++; $display("FAIL write_ch1 got=%h exp=c3", pins_out[15:8]); end
    drive(1, 0, 32'h04, 32'h0);
    #1;
    checks++;
    if (data !== 32'h0000_00C3) begin errors++; $display("FAIL read_ch1 got=%h exp=000000c3", data); end
    tick();
    drive(0, 1, 32'h40, 32'hFFFF_FFFF);
    tick();
    checks++;
    if (pins_out !== 16'hC300) begin errors++; $display("FAIL write_ignored got=%h exp=c300", pins_out); end
    drive(1, 0, 32'h40, 32'h0);
    #1;
    checks++;
    if (data !== 32'h0) begin errors++; $display("FAIL input_unwritable got=%h exp=0", data); end
    drive(1, 1, 32'h00, 32'h77);
    #1;
    checks++;
    if (data !== 32'h0) begin errors++; $display("FAIL rw_old_value got=%h exp=0", data); end
    tick();
    checks++;
    if (pins_out !== 16'hC377) begin errors++; $display("FAIL rw_write got=%h exp=c377", pins_out); end
    drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_debounce();
    pins_in = 16'h005A;
    for (int e = 1; e <= 6; e++) begin
      tick();
      drive(1, 0, 32'h40, 32'h0);
      #1;
      checks++;
      if (data !== ((e >= 6) ? 32'h5A : 32'h0)) begin
        errors++; $display("FAIL debounce_edge%0d got=%h exp=%h", e, data, (e >= 6) ? 32'h5A : 32'h0);
      end
    end
    drive(1, 0, 32'h80, 32'h0);
    #1;
    checks++;
    if (data !== 32'h1) begin errors++; $display("FAIL status_set got=%h exp=1", data); end
    tick();
    checks++;
    if (data !== 32'h0) begin errors++; $display("FAIL status_clear got=%h exp=0", data); end
    drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_glitch();
    pins_in = 16'hFF5A;
    repeat (3) tick();
    pins_in = 16'h005A;
    drive(1, 0, 32'h44, 32'h0);
    for (int e = 0; e < 10; e++) begin
      tick();
      checks++;
      if (data !== 32'h0) begin errors++; $display("FAIL glitch_deb cyc=%0d got=%h exp=0", e, data); end
    end
    drive(1, 0, 32'h80, 32'h0);
    #1;
    checks++;
    if (data !== 32'h0) begin errors++; $display("FAIL glitch_flag got=%h exp=0", data); end
    tick();
    drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_set_wins();
    pins_in = 16'h0011;
    repeat (6) tick();
    pins_in = 16'h3311;
    repeat (5) tick();
    drive(1, 0, 32'h80, 32'h0);
    #1;
    checks++;
    if (data !== 32'h1) begin errors++; $display("FAIL setwin_before got=%h exp=1", data); end
    tick();
    checks++;
    if (data !== 32'h2) begin errors++; $display("FAIL setwin_after got=%h exp=2", data); end
    tick();
    drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid();
    pins_in = 16'h3322;
    repeat (3) tick();
    rst = 1'b1;
    model_reset();
    drive(1, 0, 32'h40, 32'h0);
    #1;
    checks++;
    if (data !== 32'h0) begin errors++; $display("FAIL rstmid_deb got=%h exp=0", data); end
    drive(1, 0, 32'h80, 32'h0);
    #1;
    checks++;
    if (data !== 32'h0) begin errors++; $display("FAIL rstmid_flags got=%h exp=0", data); end
    drive(0, 0, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      drive(1, 0, 32'h40, 32'h0);
      #1;
      checks++;
      if (data !== ((e >= 6) ? 32'h22 : 32'h0)) begin
        errors++; $display("FAIL rstmid_edge%0d got=%h exp=%h", e, data, (e >= 6) ? 32'h22 : 32'h0);
      end
    end
    drive(1, 0, 32'h80, 32'h0);
    #1;
    checks++;
    if (data !== 32'h3) begin errors++; $display("FAIL rstmid_status got=%h exp=3", data); end
    tick();
    drive(0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] atab [9];
    atab = '{32'h00, 32'h04, 32'h08, 32'h40, 32'h44, 32'h48, 32'h80, 32'h84, 32'hFFFF_FF03};
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) pins_in = 16'($urandom);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
            atab[$urandom_range(0, 8)], $urandom);
      #1;
      checks++;
      if (data !== exp_read()) begin
        errors++; $display("FAIL rand_data n=%0d addr=%h got=%h exp=%h", n, addr, data, exp_read());
      end
      checks++;
      if (pins_out !== {m_out[1], m_out[0]}) begin
        errors++; $display("FAIL rand_pins_out n=%0d got=%h exp=%h", n, pins_out, {m_out[1], m_out[0]});
      end
      tick();
    end
    drive(0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    pins_in = 16'h0;
    drive(0, 0, 32'h0, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_write();
    test_debounce();
    test_glitch();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
